serial_add_ctrl: RTL and testbench

- Bit-serial adder sequencer for the sequential adder family.
- Accepts two WIDTH-bit operands plus carry-in on a start/busy/done handshake.
- Time-multiplexes one 1-bit full-adder cell over WIDTH cycles, LSB first, keeping the carry in a register between bits.
- Returns sum, carry-out and signed overflow; sits between a requesting datapath and the single shared bit-adder resource.

---
 rtl/serial_add_pkg.sv | 10 +
 rtl/serial_add_ctrl_if.sv | 26 ++
 rtl/serial_add_ctrl_fa_bit.sv | 11 +
 rtl/serial_add_ctrl.sv | 119 +++++++++++
 tb/tb_serial_add_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared constants for the serial adder sequencer: default width and FSM encoding.
package serial_add_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result handshake between a requesting datapath and the serial adder.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl_fa_bit.sv
// Single-bit full adder: the one shared arithmetic resource of the sequencer.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused LSB-first over WIDTH cycles,
// with start/busy/done handshake and held sum/cout/ovf results.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    serial_add_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] a_sr, a_sr_n;
    logic [WIDTH-1:0] b_sr, b_sr_n;
    // Holds the low WIDTH-1 sum bits; the MSB comes straight from the cell on the last step.
    logic [WIDTH-2:0] sum_sr, sum_sr_n;
    logic             carry, carry_n;
    logic [CNT_W-1:0] idx, idx_n;
    logic             busy, busy_n;
    logic             done, done_n;
    logic [WIDTH-1:0] sum, sum_n;
    logic             cout, cout_n;
    logic             ovf, ovf_n;
    logic             fa_s;
    logic             fa_co;

    fa_bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_n;
            a_sr   <= a_sr_n;
            b_sr   <= b_sr_n;
            sum_sr <= sum_sr_n;
            carry  <= carry_n;
            idx    <= idx_n;
            busy   <= busy_n;
            done   <= done_n;
            sum    <= sum_n;
            cout   <= cout_n;
            ovf    <= ovf_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        a_sr_n   = a_sr;
        b_sr_n   = b_sr;
        sum_sr_n = sum_sr;
        carry_n  = carry;
        idx_n    = idx;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        sum_n    = sum;
        cout_n   = cout;
        ovf_n    = ovf;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    a_sr_n  = bus.a;
                    b_sr_n  = bus.b;
                    carry_n = bus.cin;
                    idx_n   = '0;
                    busy_n  = 1'b1;
                    state_n = ST_RUN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sr_n   = a_sr >> 1;
                b_sr_n   = b_sr >> 1;
                sum_sr_n = (WIDTH-1)'({fa_s, sum_sr} >> 1);
                carry_n  = fa_co;
                if (idx == CNT_W'(WIDTH - 1)) begin
                    sum_n   = {fa_s, sum_sr};
                    cout_n  = fa_co;
                    ovf_n   = carry ^ fa_co;
                    done_n  = 1'b1;
                    state_n = ST_DONE;
                end else begin
                    idx_n  = idx + CNT_W'(1);
                    busy_n = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum;
    assign bus.cout = cout;
    assign bus.ovf  = ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector and random bench for serial_add_ctrl at WIDTH=8 and WIDTH=16.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8))  bus8 ();
    serial_add_ctrl_if #(.WIDTH(16)) bus16 ();

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    serial_add_ctrl #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int w, input logic st, input logic [31:0] av,
                          input logic [31:0] bv, input logic ci);
        if (w == 8) begin
            bus8.start = st; bus8.a = av[7:0]; bus8.b = bv[7:0]; bus8.cin = ci;
        end else begin
            bus16.start = st; bus16.a = av[15:0]; bus16.b = bv[15:0]; bus16.cin = ci;
        end
    endtask

    function automatic logic get_done(input int w);
        return (w == 8) ? bus8.done : bus16.done;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 8) ? bus8.busy : bus16.busy;
    endfunction

    function automatic logic [31:0] get_sum(input int w);
        return (w == 8) ? 32'(bus8.sum) : 32'(bus16.sum);
    endfunction

    function automatic logic get_cout(input int w);
        return (w == 8) ? bus8.cout : bus16.cout;
    endfunction

    function automatic logic get_ovf(input int w);
        return (w == 8) ? bus8.ovf : bus16.ovf;
    endfunction

    // Accept one operation and wait (bounded) for done; lat counts edges from accept to done.
    task automatic do_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, output logic [31:0] s, output logic co,
                         output logic ov, output int lat, output int bcnt);
        set_in(w, 1'b1, av, bv, ci);
        @(posedge clk); #1;
        set_in(w, 1'b0, av, bv, ci);
        lat  = 0;
        bcnt = 0;
        while (!get_done(w) && lat < w + 4) begin
            if (get_busy(w)) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        s  = get_sum(w);
        co = get_cout(w);
        ov = get_ovf(w);
    endtask

    // Independent reference: integer add, overflow from operand/result sign bits.
    task automatic rand_ops(input int w, input int n);
        logic [31:0] mask, av, bv, s, es;
        logic [32:0] e;
        logic        ci, co, ov, eov;
        int          lat, bcnt, nbad;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        nbad = bad;
        for (int i = 0; i < n; i++) begin
            av = $urandom() & mask;
            bv = $urandom() & mask;
            ci = 1'($urandom_range(0, 1));
            e  = 33'(av) + 33'(bv) + 33'(ci);
            es = e[31:0] & mask;
            eov = (av[w-1] == bv[w-1]) && (es[w-1] != av[w-1]);
            do_op(w, av, bv, ci, s, co, ov, lat, bcnt);
            check($sformatf("rand%0d_sum[%0d]", w, i), 64'(s), 64'(es));
            check($sformatf("rand%0d_cout[%0d]", w, i), 64'(co), 64'(e[w]));
            check($sformatf("rand%0d_ovf[%0d]", w, i), 64'(ov), 64'(eov));
            check($sformatf("rand%0d_lat[%0d]", w, i), 64'(lat), 64'(w));
            if (bad - nbad > 20) break;
        end
    endtask

    initial begin
        vec_t        vecs[7];
        logic [31:0] s;
        logic        co, ov;
        int          lat, bcnt, pulses;
        logic [7:0]  held;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

        reset = 1'b0;
        set_in(8, 1'b0, 32'h0, 32'h0, 1'b0);
        set_in(16, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus8.busy), 64'd0);
        check("rst_done", 64'(bus8.done), 64'd0);
        check("rst_sum",  64'(bus8.sum),  64'd0);
        check("rst_cout", 64'(bus8.cout), 64'd0);
        check("rst_ovf",  64'(bus8.ovf),  64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            do_op(8, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin, s, co, ov, lat, bcnt);
            check($sformatf("vec%0d_sum", i),  64'(s),    64'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i), 64'(co),   64'(vecs[i].exp_cout));
            check($sformatf("vec%0d_ovf", i),  64'(ov),   64'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_lat", i),  64'(lat),  64'd8);
            check($sformatf("vec%0d_busy", i), 64'(bcnt), 64'd8);
            check($sformatf("vec%0d_busy_at_done", i), 64'(bus8.busy), 64'd0);
        end
        @(posedge clk); #1;
        check("idle_done_low", 64'(bus8.done), 64'd0);
        check("idle_busy_low", 64'(bus8.busy), 64'd0);

        // Back-to-back: start held high through DONE
        set_in(8, 1'b1, 32'hFF, 32'hFF, 1'b1);
        @(posedge clk); #1;
        set_in(8, 1'b1, 32'h12, 32'h34, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        check("b2b_run_done_low", 64'(bus8.done), 64'd0);
        @(posedge clk); #1;
        check("b2b_first_done", 64'(bus8.done), 64'd1);
        check("b2b_first_sum",  64'(bus8.sum),  64'hFF);
        check("b2b_first_cout", 64'(bus8.cout), 64'd1);
        @(posedge clk); #1;
        set_in(8, 1'b0, 32'h12, 32'h34, 1'b0);
        check("b2b_no_bubble_busy", 64'(bus8.busy), 64'd1);
        check("b2b_no_bubble_done", 64'(bus8.done), 64'd0);
        lat = 0;
        while (!bus8.done && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_second_lat", 64'(lat), 64'd8);
        check("b2b_second_sum", 64'(bus8.sum), 64'h46);

        // Start during RUN is ignored
        @(posedge clk); #1;
        set_in(8, 1'b1, 32'h0F, 32'h01, 1'b0);
        @(posedge clk); #1;
        set_in(8, 1'b0, 32'h0F, 32'h01, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        set_in(8, 1'b1, 32'hAA, 32'h55, 1'b1);
        @(posedge clk); #1;
        set_in(8, 1'b0, 32'hAA, 32'h55, 1'b1);
        pulses = 0;
        held   = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (bus8.done) begin
                pulses++;
                held = bus8.sum;
            end
            @(posedge clk); #1;
        end
        check("ign_pulses", 64'(pulses), 64'd1);
        check("ign_sum", 64'(held), 64'h10);
        check("ign_idle_busy", 64'(bus8.busy), 64'd0);

        // Reset mid-RUN discards the operation
        set_in(8, 1'b1, 32'hFF, 32'h01, 1'b0);
        @(posedge clk); #1;
        set_in(8, 1'b0, 32'hFF, 32'h01, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("mid_rst_busy", 64'(bus8.busy), 64'd0);
        check("mid_rst_done", 64'(bus8.done), 64'd0);
        check("mid_rst_sum",  64'(bus8.sum),  64'd0);
        check("mid_rst_cout", 64'(bus8.cout), 64'd0);
        check("mid_rst_ovf",  64'(bus8.ovf),  64'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus8.done || bus8.busy) pulses++;
            @(posedge clk); #1;
        end
        check("mid_rst_stays_idle", 64'(pulses), 64'd0);
        do_op(8, 32'h05, 32'h03, 1'b0, s, co, ov, lat, bcnt);
        check("post_rst_sum", 64'(s), 64'h08);
        check("post_rst_lat", 64'(lat), 64'd8);

        // Random sweeps at both widths
        rand_ops(8, 1000);
        rand_ops(16, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
